// File: rtl/rbank_arb_if.sv
// Requester-side bus of the register-bank arbiter: requests, beat payloads, grants, read returns.
// Latency: n/a (signal bundle only).
// Backpressure: requests are held by the requester until granted.
interface rbank_arb_if #(
  parameter int NREQ = 4,
  parameter int SELW = 5,
  parameter int DW   = 64
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      lock;
  logic [NREQ-1:0]      we;
  logic [NREQ*SELW-1:0] sel;
  logic [NREQ*DW-1:0]   wdata;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      rvalid;
  logic [DW-1:0]        rdata;

  // Requester side drives the beat, arbiter side answers with grant and read data.
  modport master (output req, lock, we, sel, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, lock, we, sel, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/rbank_arb.sv
// Round-robin arbiter sharing one register-bank port among NREQ requesters, with grant locking and inhibit.
// Latency: request to grant 1 cycle; beat to bank outputs / rvalid 1 cycle; back-to-back beats every cycle.
// Backpressure: requesters hold req until gnt; inhibit blocks new grants but not an active lock.
module rbank_arb #(
  parameter int NREQ = 4,
  parameter int SELW = 5,
  parameter int DW   = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inhibit,
  rbank_arb_if.slave      rq,
  output logic            rbank_we,
  output logic [SELW-1:0] rbank_sel,
  output logic [DW-1:0]   rbank_in,
  input  logic [DW-1:0]   rbank_out
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic {IDLE, BEAT} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   rvalid_q;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     pick;
  logic              beat;
  logic [SELW-1:0]   sel_g;
  logic [DW-1:0]     wdata_g;

  // First requester after position p, wrapping; p itself is considered last.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] idx;
    rr_pick = p;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(p) + k) % NREQ);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // While in BEAT the pointer always equals the granted index, so one picker
  // serves both fresh arbitration and back-to-back re-arbitration.
  assign pick    = rr_pick(rq.req, ptr_q);
  assign sel_g   = rq.sel[int'(ptr_q)*SELW +: SELW];
  assign wdata_g = rq.wdata[int'(ptr_q)*DW +: DW];

  assign rq.gnt    = gnt_q;
  assign rq.rvalid = rvalid_q;
  assign rq.rdata  = rbank_out;

  // Next-state, next-grant and beat decision.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    beat    = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (!inhibit && (|rq.req)) begin
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          ptr_d   = pick;
          state_d = BEAT;
        end
      end
      BEAT: begin
        if (!rq.req[ptr_q]) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else begin
          beat = 1'b1;
          if (rq.lock[ptr_q]) begin
            gnt_d = gnt_q;
          end else if (!inhibit) begin
            gnt_d = {{(NREQ-1){1'b0}}, 1'b1} << pick;
            ptr_d = pick;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Arbitration state: FSM, grant and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= IW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Registered bank port and read-completion pulse; rbank_in only moves on writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rbank_we  <= 1'b0;
      rbank_sel <= '0;
      rbank_in  <= '0;
      rvalid_q  <= '0;
    end else begin
      rbank_we <= beat & rq.we[ptr_q];
      rvalid_q <= (beat && !rq.we[ptr_q]) ? gnt_q : '0;
      if (beat) rbank_sel <= sel_g;
      if (beat && rq.we[ptr_q]) rbank_in <= wdata_g;
    end
  end

`ifndef SYNTHESIS
  a_gnt_onehot:    assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt_q));
  a_rvalid_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(rvalid_q));
  a_we_after_gnt:  assert property (@(posedge clk) disable iff (!reset) rbank_we |-> ($past(gnt_q) != '0));
`endif

endmodule

// File: tb/tb_rbank_arb.sv
// Bench for rbank_arb: directed scenarios followed by random traffic, checked by a queue scoreboard.
// Latency: expected bank/read results are queued one cycle ahead of the DUT output.
// Backpressure: stimulus holds a requester's payload while it waits for a grant.
module tb_rbank_arb;
  localparam int NREQ = 4;
  localparam int SELW = 5;
  localparam int DW   = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            inhibit;
  logic            rbank_we;
  logic [SELW-1:0] rbank_sel;
  logic [DW-1:0]   rbank_in;
  logic [DW-1:0]   rbank_out;
  logic [DW-1:0]   mem [32];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  rbank_arb_if #(.NREQ(NREQ), .SELW(SELW), .DW(DW)) bus ();

  rbank_arb #(.NREQ(NREQ), .SELW(SELW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .inhibit(inhibit), .rq(bus.slave),
    .rbank_we(rbank_we), .rbank_sel(rbank_sel), .rbank_in(rbank_in), .rbank_out(rbank_out)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Register bank stand-in: combinational read, write on clock when rbank_we.
  assign rbank_out = mem[rbank_sel];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 64'(i) * 64'h11;
    forever begin
      @(posedge clk);
      if (rbank_we) mem[rbank_sel] <= rbank_in;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int              cyc;
    logic            we;
    logic [NREQ-1:0] rv;
    logic [SELW-1:0] sel;
    logic [DW-1:0]   din;
    logic [DW-1:0]   rd;
  } exp_t;

  exp_t          q[$];
  int            owner = -1;
  int            ptr = NREQ - 1;
  logic [DW-1:0] mmem [32];
  logic [DW-1:0] last_in = '0;
  bit            pw = 0;
  int            pw_sel;
  logic [DW-1:0] pw_dat;

  function automatic int scan(input logic [NREQ-1:0] r, input int p);
    for (int k = 1; k <= NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  initial for (int i = 0; i < 32; i++) mmem[i] = 64'(i) * 64'h11;

  // Model steps once per cycle on the falling edge using the inputs of that cycle.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("gnt_in_reset", 64'(bus.gnt), 64'h0);
      chk("rvalid_in_reset", 64'(bus.rvalid), 64'h0);
      chk("we_in_reset", 64'(rbank_we), 64'h0);
      owner = -1; ptr = NREQ - 1; last_in = '0; pw = 0;
      q.delete();
    end else begin
      logic [NREQ-1:0] eg;
      exp_t e;
      int g;
      if (pw) mmem[pw_sel] = pw_dat;
      pw = 0;
      eg = '0;
      if (owner >= 0) eg[owner] = 1'b1;
      chk("gnt", 64'(bus.gnt), 64'(eg));
      if (owner < 0) begin
        if (!inhibit && bus.req != '0) begin
          owner = scan(bus.req, ptr);
          ptr = owner;
        end
      end else begin
        g = owner;
        if (!bus.req[g]) begin
          owner = -1;
        end else begin
          e.cyc = cyc + 1;
          e.we  = bus.we[g];
          e.sel = bus.sel[g*SELW +: SELW];
          e.rv  = '0;
          if (e.we) begin
            last_in = bus.wdata[g*DW +: DW];
            pw = 1; pw_sel = int'(e.sel); pw_dat = last_in;
          end else begin
            e.rv[g] = 1'b1;
          end
          e.din = last_in;
          e.rd  = mmem[e.sel];
          q.push_back(e);
          if (!bus.lock[g]) begin
            if (!inhibit) begin
              owner = scan(bus.req, g);
              ptr = owner;
            end else begin
              owner = -1;
            end
          end
        end
      end
    end
  end

  // Monitor: whenever a beat result is due or the DUT shows one, compare against the queue.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("beat_we", 64'(rbank_we), 64'(e.we));
        chk("beat_rvalid", 64'(bus.rvalid), 64'(e.rv));
        chk("beat_sel", 64'(rbank_sel), 64'(e.sel));
        chk("beat_in", rbank_in, e.din);
        if (!e.we) chk("beat_rdata", bus.rdata, e.rd);
      end else if (rbank_we || bus.rvalid != '0) begin
        n_checks++; n_fail++;
        $display("FAIL spurious_beat: got we=%b rvalid=%b expected none (t=%0t)", rbank_we, bus.rvalid, $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input bit w, input logic [SELW-1:0] s,
                         input logic [DW-1:0] d, input bit lk);
    bus.req[i] = v;
    bus.we[i] = w;
    bus.sel[i*SELW +: SELW] = s;
    bus.wdata[i*DW +: DW] = d;
    bus.lock[i] = lk;
  endtask

  task automatic wait_gnt(input int i);
    bit ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.gnt[i]) begin ok = 1; break; end
    end
    chk("grant_timeout", 64'(ok), 64'h1);
  endtask

  initial begin
    inhibit = 1'b0;
    bus.req = '0; bus.lock = '0; bus.we = '0; bus.sel = '0; bus.wdata = '0;

    // Reset held with every requester asking, then rotation from requester 0.
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, SELW'(i), '0, 0);
    repeat (3) tick();
    chk("gnt_during_reset", 64'(bus.gnt), 64'h0);
    reset = 1'b1;
    tick(); chk("rot0", 64'(bus.gnt), 64'h1);
    tick(); chk("rot1", 64'(bus.gnt), 64'h2);
    tick(); chk("rot2", 64'(bus.gnt), 64'h4);
    tick(); chk("rot3", 64'(bus.gnt), 64'h8);
    tick(); chk("rot4", 64'(bus.gnt), 64'h1);
    bus.req = '0;
    tick();

    // Single write beat from requester 2.
    set_req(2, 1, 1, 5'd7, 64'hDEAD_BEEF_0000_0001, 0);
    wait_gnt(2);
    tick();
    chk("wr_we", 64'(rbank_we), 64'h1);
    chk("wr_sel", 64'(rbank_sel), 64'd7);
    chk("wr_in", rbank_in, 64'hDEAD_BEEF_0000_0001);
    bus.req[2] = 1'b0;
    tick();
    chk("wr_we_pulse", 64'(rbank_we), 64'h0);

    // Single read beat from requester 1.
    set_req(1, 1, 0, 5'd3, '0, 0);
    wait_gnt(1);
    tick();
    chk("rd_rvalid", 64'(bus.rvalid), 64'h2);
    chk("rd_rdata", bus.rdata, 64'h33);
    bus.req[1] = 1'b0;
    tick();

    // Locked grant on requester 0 for four beats with requester 3 waiting.
    set_req(0, 1, 0, 5'd1, '0, 1);
    wait_gnt(0);
    tick();
    set_req(3, 1, 0, 5'd2, '0, 0);
    chk("lock_b2", 64'(bus.gnt), 64'h1);
    tick(); chk("lock_b3", 64'(bus.gnt), 64'h1);
    tick(); chk("lock_b4", 64'(bus.gnt), 64'h1);
    bus.lock[0] = 1'b0;
    tick(); chk("lock_release", 64'(bus.gnt), 64'h8);
    bus.req[0] = 1'b0;
    tick();
    bus.req[3] = 1'b0;
    tick();

    // Inhibit blocks new grants.
    inhibit = 1'b1;
    set_req(1, 1, 0, 5'd4, '0, 0);
    set_req(2, 1, 0, 5'd5, '0, 0);
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("inhibit_gnt", 64'(bus.gnt), 64'h0);
    end
    inhibit = 1'b0;
    tick(); chk("inhibit_release", 64'(bus.gnt), 64'h2);
    bus.req[1] = 1'b0;
    tick();
    bus.req[2] = 1'b0;
    tick();

    // Asynchronous reset in the middle of a write beat.
    set_req(0, 1, 1, 5'd9, 64'h0123_4567_89AB_CDEF, 0);
    wait_gnt(0);
    tick();
    chk("mid_we_before", 64'(rbank_we), 64'h1);
    #1 reset = 1'b0;
    #1;
    chk("async_we", 64'(rbank_we), 64'h0);
    chk("async_gnt", 64'(bus.gnt), 64'h0);
    chk("async_rvalid", 64'(bus.rvalid), 64'h0);
    bus.req = '0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, SELW'(i + 10), '0, 0);
    tick(); chk("restart_gnt", 64'(bus.gnt), 64'h1);
    tick();
    bus.req = '0;
    tick();

    // Random traffic; a waiting requester keeps its payload stable.
    for (int n = 0; n < 600; n++) begin
      inhibit = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!(bus.req[i] && !bus.gnt[i]))
          set_req(i, ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1,
                  SELW'($urandom_range(0, 31)), {$urandom, $urandom},
                  ($urandom_range(0, 3) == 0));
      end
      tick();
    end

    bus.req = '0; bus.lock = '0; inhibit = 1'b0;
    repeat (5) tick();
    chk("queue_drained", 64'(q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
